// File: rtl/usb_pkg.sv
// Shared USB link-layer definitions: CRC16 constants and the TX CRC appender state encoding.
package usb_pkg;

  typedef enum logic [1:0] {
    CRC16_ST_IDLE = 2'd0,
    CRC16_ST_DATA = 2'd1,
    CRC16_ST_LO   = 2'd2,
    CRC16_ST_HI   = 2'd3
  } crc16_state_t;

  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  // Register value after a good packet including its CRC; checked by the RX side.
  localparam logic [15:0] CRC16_RESIDUAL  = 16'hB001;

endpackage

// File: rtl/crc16_byte.sv
// One-byte step of the USB CRC16 (reflected 0xA001, LSB first); purely combinational.
module crc16_byte
  import usb_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc16_t.sv
// TX data-packet CRC16 appender: passes PID/payload through with zero latency and
// appends the two complemented CRC bytes (low first), moving EOP onto the last one.
module crc16_t
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_ld_sop,
  input  logic       tx_ld_eop,
  input  logic       tx_ld_valid,
  output logic       tx_ld_ready,
  input  logic [7:0] tx_ld_data,
  input  logic       tx_ld_cancle,
  output logic       tx_lt_sop,
  output logic       tx_lt_eop,
  output logic       tx_lt_valid,
  input  logic       tx_lt_ready,
  output logic [7:0] tx_lt_data,
  output logic       tx_lt_cancle
);

  // Handshake: a beat moves on a side only in a cycle where valid && ready on that
  // side; a source holds valid and data (and sop/eop) stable until it is accepted.

  crc16_state_t state, state_next;
  logic [15:0]  crc, crc_next, crc_step;

  crc16_byte u_crc16_byte (
    .crc_in  (crc),
    .data    (tx_ld_data),
    .crc_out (crc_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CRC16_ST_IDLE;
      crc   <= CRC16_INIT;
    end else begin
      state <= state_next;
      crc   <= crc_next;
    end
  end

  assign tx_lt_cancle = tx_ld_cancle;

  always_comb begin
    state_next  = state;
    crc_next    = crc;
    tx_ld_ready = 1'b0;
    tx_lt_valid = 1'b0;
    tx_lt_sop   = 1'b0;
    tx_lt_eop   = 1'b0;
    tx_lt_data  = tx_ld_data;

    case (state)
      CRC16_ST_IDLE: begin
        // Bytes without sop are swallowed so a stray payload byte cannot wedge the source.
        tx_ld_ready = tx_ld_sop ? tx_lt_ready : 1'b1;
        tx_lt_valid = tx_ld_valid && tx_ld_sop;
        tx_lt_sop   = 1'b1;
        if (tx_ld_valid && tx_ld_sop && tx_lt_ready) begin
          crc_next   = CRC16_INIT;
          state_next = tx_ld_eop ? CRC16_ST_LO : CRC16_ST_DATA;
        end
      end
      CRC16_ST_DATA: begin
        tx_ld_ready = tx_lt_ready;
        tx_lt_valid = tx_ld_valid;
        tx_lt_sop   = tx_ld_sop;
        if (tx_ld_valid && tx_lt_ready) begin
          // A fresh sop restarts the packet: it is a PID, not payload.
          crc_next = tx_ld_sop ? CRC16_INIT : crc_step;
          if (tx_ld_eop) begin
            state_next = CRC16_ST_LO;
          end
        end
      end
      CRC16_ST_LO: begin
        tx_lt_valid = 1'b1;
        tx_lt_data  = ~crc[7:0];
        if (tx_lt_ready) begin
          state_next = CRC16_ST_HI;
        end
      end
      CRC16_ST_HI: begin
        tx_lt_valid = 1'b1;
        tx_lt_eop   = 1'b1;
        tx_lt_data  = ~crc[15:8];
        if (tx_lt_ready) begin
          state_next = CRC16_ST_IDLE;
        end
      end
      default: begin
        state_next = CRC16_ST_IDLE;
      end
    endcase

    if (tx_ld_cancle) begin
      state_next = CRC16_ST_IDLE;
      crc_next   = CRC16_INIT;
    end
  end

endmodule

// File: tb/tb_crc16_t.sv
// Scoreboard bench for crc16_t: directed packets with hand-computed USB CRC16 bytes.
module tb_crc16_t;

  logic       clk;
  logic       rst_n;
  logic       tx_ld_sop, tx_ld_eop, tx_ld_valid, tx_ld_ready, tx_ld_cancle;
  logic [7:0] tx_ld_data;
  logic       tx_lt_sop, tx_lt_eop, tx_lt_valid, tx_lt_ready, tx_lt_cancle;
  logic [7:0] tx_lt_data;

  // Expected beats: {sop, eop, data}
  logic [9:0] exp_q[$];
  int         tests;
  int         fails;
  int         cyc;
  int         eop_cyc;
  logic       bp_mode;
  logic       prev_stall;
  logic [9:0] prev_beat;
  logic [7:0] pl[16];

  crc16_t dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_ld_sop    (tx_ld_sop),
    .tx_ld_eop    (tx_ld_eop),
    .tx_ld_valid  (tx_ld_valid),
    .tx_ld_ready  (tx_ld_ready),
    .tx_ld_data   (tx_ld_data),
    .tx_ld_cancle (tx_ld_cancle),
    .tx_lt_sop    (tx_lt_sop),
    .tx_lt_eop    (tx_lt_eop),
    .tx_lt_valid  (tx_lt_valid),
    .tx_lt_ready  (tx_lt_ready),
    .tx_lt_data   (tx_lt_data),
    .tx_lt_cancle (tx_lt_cancle)
  );

  // Clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: always 1, or one cycle in 32 under backpressure
  initial begin
    tx_lt_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_lt_ready = bp_mode ? ((cyc % 32) == 0) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each accepted output beat, checks stall stability
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold", {5'd0, tx_lt_valid, tx_lt_sop, tx_lt_eop, tx_lt_data},
              {5'd0, 1'b1, prev_beat});
      end
      if (tx_lt_valid && tx_lt_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got %h with empty queue",
                   {tx_lt_sop, tx_lt_eop, tx_lt_data});
        end else begin
          check("beat", {6'd0, tx_lt_sop, tx_lt_eop, tx_lt_data}, {6'd0, exp_q.pop_front()});
        end
        if (tx_lt_eop) eop_cyc = cyc;
      end
      prev_stall = tx_lt_valid && !tx_lt_ready;
      prev_beat  = {tx_lt_sop, tx_lt_eop, tx_lt_data};
    end
  end

  // Driver: present one source byte and hold it until accepted
  task automatic send_byte(input logic [7:0] d, input logic s, input logic e, output int acc_cyc);
    tx_ld_valid = 1'b1;
    tx_ld_data  = d;
    tx_ld_sop   = s;
    tx_ld_eop   = e;
    acc_cyc     = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx_ld_ready) begin
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: byte %h never accepted", d);
    end
    @(posedge clk);
    #1;
  endtask

  // Sends PID + pl[0..n-1]; expected CRC wire bytes given by hand
  task automatic send_pkt(input logic [7:0] pid, input int n, input logic [7:0] lo,
                          input logic [7:0] hi, input logic release_valid);
    int a;
    exp_q.push_back({2'b10, pid});
    for (int i = 0; i < n; i++) exp_q.push_back({2'b00, pl[i]});
    exp_q.push_back({2'b00, lo});
    exp_q.push_back({2'b01, hi});
    send_byte(pid, 1'b1, (n == 0), a);
    for (int i = 0; i < n; i++) send_byte(pl[i], 1'b0, (i == n - 1), a);
    if (release_valid) tx_ld_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    repeat (2) @(posedge clk);
    #1;
    check(name, exp_q.size(), 16'd0);
  endtask

  task automatic load_123456789();
    for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
  endtask

  initial begin
    int a;
    int eop_seen;
    tests = 0; fails = 0; cyc = 0; eop_cyc = -1; bp_mode = 1'b0;
    prev_stall = 1'b0; prev_beat = '0;
    rst_n = 1'b0;
    tx_ld_valid = 1'b0; tx_ld_sop = 1'b0; tx_ld_eop = 1'b0;
    tx_ld_data = 8'h00; tx_ld_cancle = 1'b0;

    // Reset state follows IDLE rules
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", tx_lt_valid, 16'd0);
    check("rst_eop", tx_lt_eop, 16'd0);
    check("rst_ready", tx_ld_ready, 16'd1);
    tx_ld_cancle = 1'b1;
    #1;
    check("rst_cancel", tx_lt_cancle, 16'd1);
    tx_ld_cancle = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Stray byte without sop in IDLE: accepted and dropped
    tx_ld_valid = 1'b1; tx_ld_sop = 1'b0; tx_ld_data = 8'h77;
    @(negedge clk);
    check("drop_ready", tx_ld_ready, 16'd1);
    check("drop_valid", tx_lt_valid, 16'd0);
    @(posedge clk);
    #1;
    tx_ld_valid = 1'b0;

    // C3 + "123456789" -> CRC 0xB4C8
    load_123456789();
    send_pkt(8'hC3, 9, 8'hC8, 8'hB4, 1'b1);
    wait_drain("drain_check");

    // Zero-length packet: 4B 00 00, source stalled for two CRC cycles
    exp_q.push_back({2'b10, 8'h4B});
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b01, 8'h00});
    send_byte(8'h4B, 1'b1, 1'b1, a);
    tx_ld_valid = 1'b0;
    @(negedge clk);
    check("zl_ready_lo", tx_ld_ready, 16'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("zl_ready_hi", tx_ld_ready, 16'd0);
    @(posedge clk);
    #1;
    wait_drain("drain_zero_len");

    // Backpressure: 01 02 03 -> CRC 0x9E9E
    bp_mode = 1'b1;
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
    send_pkt(8'h5A, 3, 8'h9E, 8'h9E, 1'b1);
    wait_drain("drain_bp");
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Same payload without stalls gives the same CRC
    send_pkt(8'h5A, 3, 8'h9E, 8'h9E, 1'b1);
    wait_drain("drain_nostall");

    // Cancel after 2 of 4 payload bytes: no CRC emitted
    exp_q.push_back({2'b10, 8'h69});
    exp_q.push_back({2'b00, 8'hAA});
    exp_q.push_back({2'b00, 8'hBB});
    send_byte(8'h69, 1'b1, 1'b0, a);
    send_byte(8'hAA, 1'b0, 1'b0, a);
    send_byte(8'hBB, 1'b0, 1'b0, a);
    tx_ld_valid  = 1'b0;
    tx_ld_cancle = 1'b1;
    @(negedge clk);
    check("cancel_fwd", tx_lt_cancle, 16'd1);
    check("cancel_no_crc", tx_lt_valid, 16'd0);
    @(posedge clk);
    #1;
    tx_ld_cancle = 1'b0;
    #1;
    check("cancel_release", tx_lt_cancle, 16'd0);
    load_123456789();
    send_pkt(8'hC3, 9, 8'hC8, 8'hB4, 1'b1);
    wait_drain("drain_after_cancel");

    // Back-to-back: D2 accepted the cycle after B4
    send_pkt(8'hC3, 9, 8'hC8, 8'hB4, 1'b0);
    exp_q.push_back({2'b10, 8'hD2});
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b01, 8'h00});
    eop_cyc = -1;
    send_byte(8'hD2, 1'b1, 1'b1, a);
    eop_seen = eop_cyc;
    tx_ld_valid = 1'b0;
    check("b2b_pid_cycle", 16'(a - eop_seen), 16'd1);
    wait_drain("drain_b2b");

    // Reset asserted in CRC_LO
    exp_q.push_back({2'b10, 8'h4B});
    send_byte(8'h4B, 1'b1, 1'b1, a);
    tx_ld_valid = 1'b0;
    check("crclo_valid", tx_lt_valid, 16'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_valid_drop", tx_lt_valid, 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_queue", exp_q.size(), 16'd0);
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
    send_pkt(8'hE1, 3, 8'h9E, 8'h9E, 1'b1);
    wait_drain("drain_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/crc16_t.md
# crc16_t

TX data-packet CRC16 appender in the USB link layer. It sits directly upstream of `control_t` and takes a data packet from the link-layer TX source: a PID byte, then 0..N payload bytes. It forwards the packet to `control_t`'s `tx_lt_*` port and appends the two-byte USB CRC16 after the last payload byte, moving EOP onto the final CRC byte. The block is a zero-latency pass-through for PID and payload bytes and inserts two extra beats at the end of each packet.

## Interface
- No parameters.
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `tx_ld_sop`  in  1  first byte (PID) of the packet from the link-layer source.
- `tx_ld_eop`  in  1  last byte of the packet from the source (PID or last payload byte).
- `tx_ld_valid`  in  1  source byte valid.
- `tx_ld_ready`  out  1  block accepts the source byte this cycle.
- `tx_ld_data`  in  8  source byte.
- `tx_ld_cancle`  in  1  source aborts the current packet.
- `tx_lt_sop`  out  1  to `control_t`: first byte.
- `tx_lt_eop`  out  1  to `control_t`: last byte; always on the second CRC byte.
- `tx_lt_valid`  out  1  to `control_t`: byte valid.
- `tx_lt_ready`  in  1  `control_t` accepts the byte.
- `tx_lt_data`  out  8  to `control_t`: byte.
- `tx_lt_cancle`  out  1  abort forwarded to `control_t`.

## Operation
- Transfer rules:
  - A transfer occurs on a cycle with valid && ready on that side.
  - `tx_ld_valid` and `tx_ld_data` are held until accepted.
- CRC16 definition (USB):
  - poly x^16+x^15+x^2+1, processed LSB-first (reflected 0xA001).
  - init 0xFFFF; output is the one's complement of the register.
  - Sent low byte first: CRC_LO = ~crc[7:0], then CRC_HI = ~crc[15:8].
  - Covers payload only; the PID is excluded.
- FSM states: IDLE, DATA, CRC_LO, CRC_HI.
- IDLE:
  - `tx_ld_ready` = `tx_lt_ready`. `tx_lt_valid` = `tx_ld_valid && tx_ld_sop`. Data is passed through. `tx_lt_sop`=1, `tx_lt_eop`=0.
  - A byte without sop is dropped: ready=1, nothing is forwarded.
  - On PID accepted: crc <= 0xFFFF. Go to CRC_LO if `tx_ld_eop` is set (zero-length packet), otherwise go to DATA.
- DATA:
  - `tx_ld_ready` = `tx_lt_ready`, `tx_lt_valid` = `tx_ld_valid`, data passed through, `tx_lt_eop` = 0.
  - On each accepted byte: crc <= next(crc, byte).
  - If the accepted byte has eop, go to CRC_LO.
  - If the accepted byte has sop: forward it with `tx_lt_sop`=1, crc <= 0xFFFF, treat it as a new PID, stay in DATA (or go to CRC_LO if it also has eop).
- CRC_LO:
  - `tx_ld_ready`=0, `tx_lt_valid`=1, data = ~crc[7:0], sop=0, eop=0.
  - Go to CRC_HI on `tx_lt_ready`.
- CRC_HI:
  - `tx_ld_ready`=0, `tx_lt_valid`=1, data = ~crc[15:8], eop=1.
  - Go to IDLE on `tx_lt_ready`.
- Cancel:
  - `tx_lt_cancle` = `tx_ld_cancle` (combinational).
  - On any cycle with `tx_ld_cancle`=1: next state is IDLE and crc <= 0xFFFF. A byte transfer in the same cycle is ignored for the CRC.
  - Cancel in CRC_LO or CRC_HI also aborts the packet.

## Timing
- Reset state: IDLE, crc=0xFFFF.
- Outputs during reset follow the IDLE rules:
  - `tx_lt_valid` = `tx_ld_valid && tx_ld_sop`, `tx_lt_eop`=0, `tx_lt_cancle` = `tx_ld_cancle`.
  - The upstream source holds valid=0 while `rst_n`=0.
- Latency: PID and payload 0 cycles (combinational path).
- CRC insertion:
  - The CRC bytes follow the last payload byte with no idle cycle when `tx_lt_ready`=1.
  - A packet of N payload bytes occupies N+3 accepted output beats.
- Back-to-back packets:
  - A new PID is accepted in the cycle after CRC_HI completes (IDLE).
  - There is no bubble on the input side beyond the 2 CRC cycles.
- Backpressure: `tx_lt_ready`=0 holds every output stable in every state.
- Reset mid-packet: asynchronous return to IDLE. The partial packet is not completed and no CRC is emitted.

## Structure
- Shared package `usb_pkg`, holding:
  - state encoding `crc16_state_t`
  - `CRC16_INIT` = 16'hFFFF
  - `CRC16_POLY_REFL` = 16'hA001
  - `CRC16_RESIDUAL` = 16'hB001 (register value after a valid packet including its CRC, used by the RX checker)
- Sub-module `crc16_byte`: combinational next-CRC function (crc[15:0], byte[7:0] -> crc[15:0]). It is reused by the RX CRC16 checker.

## Test plan
- Packet with PID 0xC3 and payload "123456789" (0x31..0x39), ready always 1:
  - Output is C3 31..39 C8 B4 (CRC 0xB4C8).
  - sop on C3 only, eop on B4 only.
- Zero-length packet, PID 0x4B with sop+eop:
  - Output is 4B 00 00, eop on the second 00.
  - `tx_ld_ready`=0 for the 2 CRC cycles.
- Backpressure:
  - Stimulus: payload 01 02 03 with `tx_lt_ready` pulsing 1 cycle in 32; ready also held low during CRC_LO.
  - Required: data and valid held stable; no byte is duplicated or lost; CRC matches the no-stall run.
- Cancel after 2 of 4 payload bytes:
  - `tx_lt_cancle` pulses in the same cycle; no CRC bytes are emitted.
  - The next packet C3 31..39 still yields C8 B4.
- Back-to-back packets C3+"123456789", then D2 (zero-length):
  - Second PID is accepted the cycle after B4 is accepted.
  - Output 00 00 follows D2.
- `rst_n` asserted in CRC_LO:
  - `tx_lt_valid` drops immediately.
  - After release the block is in IDLE and the next packet is correct.
